// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - shared types and constants for the SPI flash game-image streamer
// The optional wake sequence states exist only when SPI_FLASH_WAKE_EN is defined.
package flash_loader_pkg;

    localparam int BYTE_CNT_W = 23;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_CMD_WAKE = 8'hAB;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef SPI_FLASH_WAKE_EN
        ST_WAKE,
        ST_WAKE_GAP,
`endif
        ST_CMD,
        ST_DATA,
        ST_END
    } flash_state_t;

endpackage

// File: rtl/spi_flash_streamer_if.sv
// rtl/spi_flash_streamer_if.sv - SPI NOR flash pin bundle (streamer drives, flash answers)
interface spi_flash_streamer_if;

    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso
    );

endinterface

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SCK divider plus 8-bit full-duplex SPI mode-0 shifter
// Holding go high at the last falling edge chains the next byte with no SCK gap.
module spi_byte_engine #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       abort,
    input  logic       rx_en,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    logic       active;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic       phase_end;

    assign phase_end = active && (div_cnt == PHASE_LAST);
    assign mosi      = tx_sr[7];

    always_ff @(posedge clk) begin
        if (!reset) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_byte <= '0;
            sck     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                active  <= 1'b0;
                sck     <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                tx_sr   <= '0;
            end else if (!active) begin
                if (go) begin
                    active  <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    tx_sr   <= tx_byte;
                end
            end else if (!phase_end) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= '0;
                sck     <= !sck;
                if (!sck) begin
                    // Rising edge: MISO is captured in the cycle that raises SCK.
                    rx_sr <= {rx_sr[5:0], miso};
                    if (bit_cnt == 3'd7) begin
                        done <= 1'b1;
                        if (rx_en) begin
                            rx_byte <= {rx_sr, miso};
                        end
                    end
                end else if (bit_cnt == 3'd7) begin
                    bit_cnt <= '0;
                    if (go) begin
                        tx_sr <= tx_byte;
                    end else begin
                        active <= 1'b0;
                        tx_sr  <= '0;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    tx_sr   <= {tx_sr[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_streamer.sv
// rtl/spi_flash_streamer.sv - streams an iNES image from SPI NOR flash as byte strobes
// Optional flash wake-up (0xAB plus idle gap) is built in when SPI_FLASH_WAKE_EN is defined.
module spi_flash_streamer
    import flash_loader_pkg::*;
#(
    parameter int unsigned            CLK_DIV    = 2,
    parameter logic [23:0]            FLASH_BASE = 24'h10_0000,
    parameter logic [BYTE_CNT_W-1:0]  MAX_BYTES  = 23'h40_0010
`ifdef SPI_FLASH_WAKE_EN
    , parameter int unsigned          WAKE_WAIT  = 200
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    spi_flash_streamer_if.master  spi,
    output logic [7:0]            out_data,
    output logic                  out_strobe,
    output logic                  busy,
    output logic                  finished
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = MAX_BYTES - 23'd1;
`ifdef SPI_FLASH_WAKE_EN
    localparam flash_state_t FIRST_ST = ST_WAKE;
    localparam logic [15:0]  GAP_LAST = 16'(WAKE_WAIT - 1);
`else
    localparam flash_state_t FIRST_ST = ST_CMD;
`endif

    flash_state_t state, state_d;

    logic                  cs_n;
    logic                  cs_active;
    logic [31:0]           cmd_sr;
    logic [1:0]            cmd_cnt;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  last_byte;
    logic                  eng_go;
    logic                  eng_abort;
    logic                  eng_rx_en;
    logic [7:0]            eng_tx;
    logic                  eng_done;
    logic                  eng_sck;
    logic                  eng_mosi;
`ifdef SPI_FLASH_WAKE_EN
    logic [15:0]           gap_cnt;
`endif

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (clk),
        .reset   (reset),
        .go      (eng_go),
        .abort   (eng_abort),
        .rx_en   (eng_rx_en),
        .tx_byte (eng_tx),
        .miso    (spi.spi_miso),
        .done    (eng_done),
        .rx_byte (out_data),
        .sck     (eng_sck),
        .mosi    (eng_mosi)
    );

    assign spi.spi_cs_n = cs_n;
    assign spi.spi_sck  = eng_sck;
    assign spi.spi_mosi = eng_mosi;

    // Terminal compare on the pre-increment count so the counter never wraps.
    assign last_byte = (byte_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        eng_go     = 1'b0;
        eng_abort  = 1'b0;
        eng_rx_en  = 1'b0;
        eng_tx     = 8'h00;
        cs_active  = 1'b0;
        out_strobe = 1'b0;
        unique case (state)
            ST_IDLE: begin
                eng_abort = 1'b1;
                if (start) begin
                    state_d = (MAX_BYTES == '0) ? ST_END : FIRST_ST;
                end
            end
`ifdef SPI_FLASH_WAKE_EN
            ST_WAKE: begin
                cs_active = 1'b1;
                eng_go    = !eng_done;
                eng_tx    = FLASH_CMD_WAKE;
                if (eng_done) begin
                    state_d = ST_WAKE_GAP;
                end
            end
            ST_WAKE_GAP: begin
                eng_abort = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_d = ST_CMD;
                end
            end
`endif
            ST_CMD: begin
                cs_active = 1'b1;
                eng_go    = 1'b1;
                // With CLK_DIV=1 the reload edge falls at the end of the done cycle,
                // before cmd_sr has shifted, so present the following byte early.
                eng_tx    = eng_done ? cmd_sr[23:16] : cmd_sr[31:24];
                if (eng_done && (cmd_cnt == 2'd3)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cs_active  = 1'b1;
                eng_rx_en  = 1'b1;
                out_strobe = eng_done;
                eng_go     = !(eng_done && (last_byte || stop));
                if (eng_done && (last_byte || stop)) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                eng_abort = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            finished <= 1'b0;
            cmd_sr   <= '0;
            cmd_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            cs_n <= !cs_active;
            if ((state == ST_IDLE) && start) begin
                busy     <= 1'b1;
                finished <= 1'b0;
                cmd_sr   <= {FLASH_CMD_READ, FLASH_BASE};
                cmd_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (state == ST_END) begin
                busy     <= 1'b0;
                finished <= 1'b1;
            end
            if ((state == ST_CMD) && eng_done) begin
                cmd_sr  <= {cmd_sr[23:0], 8'h00};
                cmd_cnt <= cmd_cnt + 2'd1;
            end
            if (out_strobe) begin
                byte_cnt <= byte_cnt + 23'd1;
            end
        end
    end

`ifdef SPI_FLASH_WAKE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (state == ST_WAKE_GAP) begin
            gap_cnt <= gap_cnt + 16'd1;
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

endmodule
